// File: rtl/v_pkg.sv
// Shared definitions for the vector load/store sequencer.
// Holds datapath widths, the sequencer state encoding and the latched command layout.
package v_pkg;

  localparam int VLEN    = 512;
  localparam int VMEM_AW = 64;
  localparam int VREG_AW = 5;
  localparam int VBYTES  = VLEN / 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    STORE,
    DRAIN,
    DONE
  } state_t;

  typedef struct packed {
    logic               store;
    logic [VMEM_AW-1:0] base;
    logic [VREG_AW-1:0] vreg;
    logic [2:0]         nreg_m1;
    logic [VMEM_AW-1:0] stride;
  } cmd_t;

endpackage

// File: rtl/v_lsu_addr_gen.sv
// Beat counter plus address / register-index generator for v_lsu_seq.
// Latches the command on start, then steps address and register index once per issued beat.
// Optional macro V_LSU_STRIDE_EN: when defined the latched command stride is the
// per-beat address step; otherwise the step is one register width (VBYTES).
module v_lsu_addr_gen
  import v_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               adv,
  input  cmd_t               cmd,
  output logic [VMEM_AW-1:0] addr,
  output logic [VREG_AW-1:0] vreg_idx,
  output logic               last
);

  logic [VMEM_AW-1:0] addr_q;
  logic [VMEM_AW-1:0] step_q;
  logic [VMEM_AW-1:0] step_d;
  logic [VREG_AW-1:0] idx_q;
  logic [2:0]         cnt_q;
  logic [2:0]         nreg_q;
  logic               unused_cmd;

`ifdef V_LSU_STRIDE_EN
  assign step_d     = cmd.stride;
  assign unused_cmd = cmd.store;
`else
  assign step_d     = VMEM_AW'(VBYTES);
  assign unused_cmd = cmd.store ^ (^cmd.stride);
`endif

  // Latch the command on acceptance, advance address/index/count on every issued beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
      step_q <= '0;
      idx_q  <= '0;
      cnt_q  <= '0;
      nreg_q <= '0;
    end else if (start) begin
      addr_q <= cmd.base;
      step_q <= step_d;
      idx_q  <= cmd.vreg;
      cnt_q  <= '0;
      nreg_q <= cmd.nreg_m1;
    end else if (adv) begin
      // Both sums wrap naturally at their register widths
      addr_q <= addr_q + step_q;
      idx_q  <= idx_q + VREG_AW'(1);
      cnt_q  <= cnt_q + 3'd1;
    end
  end

  assign addr     = addr_q;
  assign vreg_idx = idx_q;
  assign last     = (cnt_q == nreg_q);

endmodule

// File: rtl/v_lsu_seq.sv
// Vector load/store sequencer: splits one whole-register command into 1-8 beats,
// drives the vmem strobes/address/store data and writes load returns into the VRF.
// Optional macro V_LSU_STRIDE_EN enables strided beat addressing (see v_lsu_addr_gen).
module v_lsu_seq
  import v_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid_i,
  output logic               cmd_ready_o,
  input  logic               cmd_store_i,
  input  logic [VMEM_AW-1:0] cmd_base_i,
  input  logic [VREG_AW-1:0] cmd_vreg_i,
  input  logic [2:0]         cmd_nreg_m1_i,
  input  logic [VMEM_AW-1:0] cmd_stride_i,
  output logic [VREG_AW-1:0] vrf_raddr_o,
  input  logic [VLEN-1:0]    vrf_rdata_i,
  output logic               vrf_wen_o,
  output logic [VREG_AW-1:0] vrf_waddr_o,
  output logic [VLEN-1:0]    vrf_wdata_o,
  output logic               vmem_ren_o,
  output logic               vmem_wen_o,
  output logic [VMEM_AW-1:0] vmem_addr_o,
  output logic [VLEN-1:0]    vmem_din_o,
  input  logic [VLEN-1:0]    vmem_dout_i,
  output logic               busy_o,
  output logic               done_o
);

  state_t             state_q;
  state_t             state_d;
  cmd_t               cmd_in;
  logic               accept;
  logic               beat;
  logic [VMEM_AW-1:0] beat_addr;
  logic [VREG_AW-1:0] beat_idx;
  logic               beat_last;
  logic               ret_vld_p1;
  logic [VREG_AW-1:0] ret_idx_p1;

  assign cmd_in.store   = cmd_store_i;
  assign cmd_in.base    = cmd_base_i;
  assign cmd_in.vreg    = cmd_vreg_i;
  assign cmd_in.nreg_m1 = cmd_nreg_m1_i;
  assign cmd_in.stride  = cmd_stride_i;

  assign cmd_ready_o = (state_q == IDLE);
  assign accept      = cmd_valid_i && cmd_ready_o;
  assign beat        = (state_q == LOAD) || (state_q == STORE);

  v_lsu_addr_gen u_addr_gen (
    .clk      (clk),
    .rst      (rst),
    .start    (accept),
    .adv      (beat),
    .cmd      (cmd_in),
    .addr     (beat_addr),
    .vreg_idx (beat_idx),
    .last     (beat_last)
  );

  // Sequencer state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: beats run back to back, loads add one drain cycle for the last return
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = cmd_store_i ? STORE : LOAD;
      STORE:   if (beat_last) state_d = DONE;
      LOAD:    if (beat_last) state_d = DRAIN;
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // p0 -> p1: load beat issued, memory data arrives next cycle; carry its VRF index along
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ret_vld_p1 <= 1'b0;
      ret_idx_p1 <= '0;
    end else begin
      ret_vld_p1 <= (state_q == LOAD);
      ret_idx_p1 <= beat_idx;
    end
  end

  assign vmem_ren_o  = (state_q == LOAD);
  assign vmem_wen_o  = (state_q == STORE);
  assign vmem_addr_o = beat_addr;
  assign vrf_raddr_o = beat_idx;
  assign vmem_din_o  = vrf_rdata_i;

  assign vrf_wen_o   = ret_vld_p1;
  assign vrf_waddr_o = ret_idx_p1;
  assign vrf_wdata_o = vmem_dout_i;

  assign busy_o = (state_q == LOAD) || (state_q == STORE) || (state_q == DRAIN);
  assign done_o = (state_q == DONE);

endmodule

// File: tb/tb_v_lsu_seq.sv
// Scoreboard bench for v_lsu_seq: stimulus pushes expected memory beats, VRF writes
// and done pulses (with their cycle numbers) into queues; a negedge monitor pops and compares.
module tb_v_lsu_seq;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         cmd_valid_i = 1'b0;
  logic         cmd_ready_o;
  logic         cmd_store_i = 1'b0;
  logic [63:0]  cmd_base_i = '0;
  logic [4:0]   cmd_vreg_i = '0;
  logic [2:0]   cmd_nreg_m1_i = '0;
  logic [63:0]  cmd_stride_i = '0;
  logic [4:0]   vrf_raddr_o;
  logic [511:0] vrf_rdata_i;
  logic         vrf_wen_o;
  logic [4:0]   vrf_waddr_o;
  logic [511:0] vrf_wdata_o;
  logic         vmem_ren_o;
  logic         vmem_wen_o;
  logic [63:0]  vmem_addr_o;
  logic [511:0] vmem_din_o;
  logic [511:0] vmem_dout_i = '0;
  logic         busy_o;
  logic         done_o;

  v_lsu_seq dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_valid_i   (cmd_valid_i),
    .cmd_ready_o   (cmd_ready_o),
    .cmd_store_i   (cmd_store_i),
    .cmd_base_i    (cmd_base_i),
    .cmd_vreg_i    (cmd_vreg_i),
    .cmd_nreg_m1_i (cmd_nreg_m1_i),
    .cmd_stride_i  (cmd_stride_i),
    .vrf_raddr_o   (vrf_raddr_o),
    .vrf_rdata_i   (vrf_rdata_i),
    .vrf_wen_o     (vrf_wen_o),
    .vrf_waddr_o   (vrf_waddr_o),
    .vrf_wdata_o   (vrf_wdata_o),
    .vmem_ren_o    (vmem_ren_o),
    .vmem_wen_o    (vmem_wen_o),
    .vmem_addr_o   (vmem_addr_o),
    .vmem_din_o    (vmem_din_o),
    .vmem_dout_i   (vmem_dout_i),
    .busy_o        (busy_o),
    .done_o        (done_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int           cyc;
    logic         wr;
    logic [63:0]  addr;
    logic [511:0] data;
  } mem_e_t;

  typedef struct {
    int           cyc;
    logic [4:0]   idx;
    logic [511:0] data;
  } wb_e_t;

  mem_e_t exp_mem[$];
  wb_e_t  exp_wb[$];
  int     exp_done[$];

  logic [511:0] vrf_model [32];

  always @(posedge clk) cyc <= cyc + 1;

  // Fixed, address-derived memory contents
  function automatic logic [511:0] memfn(input logic [63:0] a);
    logic [511:0] r;
    for (int j = 0; j < 8; j++) r[j*64 +: 64] = a ^ (64'h9E3779B97F4A7C15 * 64'(j + 1));
    return r;
  endfunction

  function automatic logic [511:0] rnd512();
    logic [511:0] r;
    for (int j = 0; j < 16; j++) r[j*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // VRF read port: combinational read of the bench's register contents
  assign vrf_rdata_i = vrf_model[vrf_raddr_o];

  // Memory: data for a read appears exactly one cycle later, garbage otherwise
  always @(posedge clk) vmem_dout_i <= vmem_ren_o ? memfn(vmem_addr_o) : rnd512();

  // Monitor
  always @(negedge clk) begin
    mem_e_t me;
    wb_e_t  we;
    int     dc;
    if (!rst) begin
      if (vmem_ren_o && vmem_wen_o) chk("both_strobes", 1, 0);
      if (vmem_ren_o || vmem_wen_o) begin
        if (exp_mem.size() == 0) chk("unexpected_strobe", 1, 0);
        else begin
          me = exp_mem.pop_front();
          chk("mem_cyc", 512'(cyc), 512'(me.cyc));
          chk("mem_wr", 512'(vmem_wen_o), 512'(me.wr));
          chk("mem_addr", 512'(vmem_addr_o), 512'(me.addr));
          if (me.wr) chk("mem_din", vmem_din_o, me.data);
        end
      end else if (exp_mem.size() > 0 && exp_mem[0].cyc <= cyc) begin
        me = exp_mem.pop_front();
        chk("missed_strobe_cyc", 0, 512'(me.cyc));
      end
      if (vrf_wen_o) begin
        if (exp_wb.size() == 0) chk("unexpected_vrf_wen", 1, 0);
        else begin
          we = exp_wb.pop_front();
          chk("wb_cyc", 512'(cyc), 512'(we.cyc));
          chk("wb_addr", 512'(vrf_waddr_o), 512'(we.idx));
          chk("wb_data", vrf_wdata_o, we.data);
        end
      end else if (exp_wb.size() > 0 && exp_wb[0].cyc <= cyc) begin
        we = exp_wb.pop_front();
        chk("missed_vrf_wen_cyc", 0, 512'(we.cyc));
      end
      if (done_o) begin
        chk("done_busy", 512'(busy_o), 0);
        if (exp_done.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          dc = exp_done.pop_front();
          chk("done_cyc", 512'(cyc), 512'(dc));
        end
      end else if (exp_done.size() > 0 && exp_done[0] <= cyc) begin
        dc = exp_done.pop_front();
        chk("missed_done_cyc", 0, 512'(dc));
      end
    end
  end

  task automatic wait_ready();
    int t = 0;
    @(negedge clk);
    while (!cmd_ready_o && t < 64) begin
      @(negedge clk);
      t++;
    end
    if (t >= 64) chk("ready_timeout", 0, 1);
  endtask

  task automatic issue(input logic st, input logic [63:0] base, input logic [4:0] vr,
                       input logic [2:0] nm1, input logic [63:0] stride, input bit hold);
    int          n;
    int          c0;
    int          t;
    logic [63:0] step;
    logic [63:0] a;
    logic [4:0]  idx;
    wait_ready();
    cmd_valid_i   = 1'b1;
    cmd_store_i   = st;
    cmd_base_i    = base;
    cmd_vreg_i    = vr;
    cmd_nreg_m1_i = nm1;
    cmd_stride_i  = stride;
    c0 = cyc;
    n  = int'(nm1) + 1;
`ifdef V_LSU_STRIDE_EN
    step = stride;
`else
    step = 64'd64;
`endif
    for (int k = 0; k < n; k++) begin
      a   = base + 64'(k) * step;
      idx = vr + 5'(k);
      exp_mem.push_back('{cyc: c0 + 1 + k, wr: st, addr: a, data: st ? vrf_model[idx] : '0});
      if (!st) exp_wb.push_back('{cyc: c0 + 2 + k, idx: idx, data: memfn(a)});
    end
    exp_done.push_back(c0 + 1 + n + (st ? 0 : 1));
    @(posedge clk);
    @(negedge clk);
    cmd_valid_i   = hold;
    cmd_store_i   = $urandom_range(0, 1);
    cmd_base_i    = {$urandom, $urandom};
    cmd_vreg_i    = 5'($urandom);
    cmd_nreg_m1_i = 3'($urandom);
    cmd_stride_i  = {$urandom, $urandom};
    if (hold) begin
      t = 0;
      while (!done_o && t < 20) begin
        chk("ready_while_busy", 512'(cmd_ready_o), 0);
        cmd_base_i = {$urandom, $urandom};
        @(negedge clk);
        t++;
      end
      if (t >= 20) chk("hold_done_timeout", 0, 1);
      cmd_valid_i = 1'b0;
    end
  endtask

  task automatic check_reset_outputs();
    chk("rst_busy", 512'(busy_o), 0);
    chk("rst_done", 512'(done_o), 0);
    chk("rst_ren", 512'(vmem_ren_o), 0);
    chk("rst_wen", 512'(vmem_wen_o), 0);
    chk("rst_vrf_wen", 512'(vrf_wen_o), 0);
    chk("rst_addr", 512'(vmem_addr_o), 0);
    chk("rst_raddr", 512'(vrf_raddr_o), 0);
    chk("rst_waddr", 512'(vrf_waddr_o), 0);
    chk("rst_ready", 512'(cmd_ready_o), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int r = 0; r < 32; r++) vrf_model[r] = rnd512();
    #2 rst = 1'b1;
    #1 check_reset_outputs();
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    issue(1'b0, 64'h1000, 5'd4, 3'd1, 64'h40, 1'b0);
    issue(1'b1, 64'h2000, 5'd8, 3'd0, 64'h40, 1'b0);
    issue(1'b0, 64'h3000, 5'd30, 3'd3, 64'h40, 1'b0);
    issue(1'b1, 64'hFFFF_FFFF_FFFF_FFC0, 5'd12, 3'd1, 64'h40, 1'b0);
`ifdef V_LSU_STRIDE_EN
    issue(1'b0, 64'h100, 5'd2, 3'd2, 64'h200, 1'b0);
    issue(1'b1, 64'h700, 5'd3, 3'd2, 64'h0, 1'b0);
`endif
    issue(1'b1, 64'h4000, 5'd1, 3'd2, 64'h40, 1'b1);
    issue(1'b0, 64'h5000, 5'd9, 3'd1, 64'h40, 1'b1);

    for (int i = 0; i < 24; i++)
      issue(1'($urandom_range(0, 1)), {$urandom, $urandom}, 5'($urandom), 3'($urandom),
            {$urandom, $urandom}, ($urandom_range(0, 3) == 0));

    // Abandon an 8-beat load partway through
    issue(1'b0, 64'h8000, 5'd16, 3'd7, 64'h40, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check_reset_outputs();
    exp_mem.delete();
    exp_wb.delete();
    exp_done.delete();
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    repeat (6) @(posedge clk);

    issue(1'b0, 64'h9000, 5'd31, 3'd1, 64'h40, 1'b0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("queues_empty", 512'(exp_mem.size() + exp_wb.size() + exp_done.size()), 0);
    chk("idle_at_end", 512'(cmd_ready_o), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/v_lsu_seq.md
Name: v_lsu_seq

Overview:
- Vector load/store sequencer directly upstream of the vector memory access stage.
- Accepts one whole-register vector load/store command, splits it into 1-8 register-sized beats, and drives the vmem read/write strobes, address and store data.
- On loads, returns read data into the vector register file (VRF).
- One beat per cycle; a completion pulse is raised when the command finishes.

Parameters:
- VLEN, 512: vector register width in bits; equals the VMEM data width.
- VMEM_AW, 64: byte address width.
- VREG_AW, 5: VRF index width (32 registers).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- cmd_valid_i  in  1  command valid
- cmd_ready_o  out  1  sequencer can accept a command
- cmd_store_i  in  1  1 = store, 0 = load
- cmd_base_i  in  VMEM_AW  byte base address
- cmd_vreg_i  in  VREG_AW  first register (vd for loads, vs3 for stores)
- cmd_nreg_m1_i  in  3  register count minus one (0..7 → 1..8 beats)
- cmd_stride_i  in  VMEM_AW  byte stride between beats (used only with the optional feature)
- vrf_raddr_o  out  VREG_AW  VRF read index for store data
- vrf_rdata_i  in  VLEN  VRF read data (combinational read)
- vrf_wen_o  out  1  VRF write enable (load return)
- vrf_waddr_o  out  VREG_AW  VRF write index
- vrf_wdata_o  out  VLEN  VRF write data
- vmem_ren_o  out  1  memory read strobe
- vmem_wen_o  out  1  memory write strobe
- vmem_addr_o  out  VMEM_AW  beat byte address
- vmem_din_o  out  VLEN  store data
- vmem_dout_i  in  VLEN  load data, valid exactly 1 cycle after vmem_ren_o
- busy_o  out  1  a command is in flight
- done_o  out  1  one-cycle pulse when a command completes

Behaviour:
- Reset (async, rst=1):
  - State → IDLE.
  - busy_o, done_o, vmem_ren_o, vmem_wen_o, vrf_wen_o all 0.
  - vmem_addr_o, vrf_raddr_o, vrf_waddr_o all 0.
  - Beat counter and load-return pipeline cleared.
  - Reset mid-command abandons the command; no further strobes; any pending load return is dropped.
- Handshake:
  - cmd_ready_o = (state == IDLE).
  - A command is accepted when cmd_valid_i && cmd_ready_o at a rising edge.
  - Command fields are latched on acceptance; later input changes are ignored.
- States:
  - IDLE → LOAD or STORE on acceptance; busy_o = 1 from the next cycle.
  - STORE: one beat per cycle, beat k = 0..N-1.
    - vmem_wen_o = 1, vmem_addr_o = base + k*STEP.
    - vrf_raddr_o = vreg + k; vmem_din_o = vrf_rdata_i, combinational in the same cycle.
    - After beat N-1 → DONE.
  - LOAD: one beat per cycle.
    - vmem_ren_o = 1, vmem_addr_o = base + k*STEP.
    - A 1-deep return pipeline registers the beat index.
    - In the next cycle: vrf_wen_o = 1, vrf_waddr_o = vreg + k, vrf_wdata_o = vmem_dout_i.
    - After beat N-1 is issued → DRAIN.
  - DRAIN: no memory strobe; final VRF writeback occurs; → DONE.
  - DONE: done_o = 1 for one cycle, busy_o = 0; → IDLE. cmd_ready_o rises in the cycle after DONE.
- Latency, first beat issued in the cycle after acceptance:
  - Store: N beat cycles + 1 DONE cycle.
  - Load: N beat cycles + 1 DRAIN cycle + 1 DONE cycle.
- Arithmetic:
  - STEP = VLEN/8 (64 bytes).
  - Address sums are computed modulo 2^VMEM_AW (wrap, no error).
  - Register index vreg + k is computed modulo 2^VREG_AW (v31 + 1 → v0).
- vmem_ren_o and vmem_wen_o are never both 1.
- Strobes are 0 in IDLE, DRAIN and DONE.
- Address and data outputs are don't-care when no strobe is active.

Optional Feature:
- Macro: V_LSU_STRIDE_EN.
- Defined: cmd_stride_i is latched at acceptance. Beat address = base + k*stride, modulo 2^VMEM_AW. Stride 0 is legal and repeats the same address.
- Undefined: cmd_stride_i is ignored and unit stride STEP is used. The port still exists.

Decomposition:
- Shared package v_pkg holds:
  - localparams VLEN, VMEM_AW, VREG_AW, VBYTES = VLEN/8.
  - State enum typedef: IDLE, LOAD, STORE, DRAIN, DONE.
  - Command struct typedef: store, base, vreg, nreg_m1, stride.
- One sub-module, v_lsu_addr_gen, holds the beat counter and the address/register-index generator. The FSM lives in the top module.

Test Plan:
- Unit-stride load, base 0x1000, vd = 4, nreg_m1 = 1:
  - vmem_ren_o at cycles 1-2 with addresses 0x1000 and 0x1040.
  - VRF writes v4 and v5 at cycles 2-3 with the returned data.
  - done_o pulses at cycle 4.
- Store, base 0x2000, vs3 = 8, nreg_m1 = 0:
  - One vmem_wen_o cycle, addr 0x2000, vmem_din_o = v8 contents.
  - done_o in the following cycle.
- Register wrap, load, vd = 30, nreg_m1 = 3 → VRF writes to v30, v31, v0, v1.
- Address wrap, store, base 0xFFFF_FFFF_FFFF_FFC0, nreg_m1 = 1 → addresses 0x...FFC0, then 0x0.
- Back-pressure and reset:
  - cmd_valid_i held high while busy → cmd_ready_o stays 0 and no second command is accepted until after done_o.
  - rst asserted in the middle of an 8-beat load → all outputs 0 immediately; no further VRF writes.
- With V_LSU_STRIDE_EN, load, base 0x100, stride 0x200, nreg_m1 = 2 → addresses 0x100, 0x300, 0x500.
